dbus_region_decoder: RTL and testbench
======================================

// Module: dbus_region_decoder
// PURPOSE
//  Parametrised data-bus interconnect between the Cpu data port and NSLAVE memory-mapped slaves
//  (boot ROM port 2, data RAM, GPO, future peripherals). Replaces the fixed single-bit address
//  split with an N-way region decode.
//  Adds per-region wait states, a req/ready handshake, a registered read-data return and an
//  error response for unmapped regions.
// PARAMETERS
//  ADDR_W   11             master address width (bytes)
//  DATA_W   32             data width
//  NSLAVE   4              number of slave regions (power of two, >=2)
//  SEL_W    2              log2(NSLAVE); region = m_addr[ADDR_W-1 -: SEL_W]
//  LAT_VEC  16'h0000       packed 4-bit extra wait cycles per region, region r at [4r+3:4r]
//  MAP_MASK {NSLAVE{1'b1}} bit r = 1 -> region r mapped; 0 -> access returns error
// PORTS
//  clk      in   1                  rising-edge clock
//  rst_n    in   1                  asynchronous active-low reset
//  m_req    in   1                  master request; held high until m_ready
//  m_addr   in   ADDR_W             master byte address
//  m_wdata  in   DATA_W             master write data
//  m_width  in   4                  byte-lane enables
//  m_write  in   1                  1 = write, 0 = read
//  m_ready  out  1                  one-cycle completion pulse
//  m_err    out  1                  valid with m_ready; 1 = unmapped region
//  m_rdata  out  DATA_W             registered read data, valid when m_ready & ~m_write
//  s_sel    out  NSLAVE             one-hot slave strobe
//  s_addr   out  ADDR_W-SEL_W       region-local address, registered
//  s_wdata  out  DATA_W             registered write data
//  s_width  out  4                  registered byte enables
//  s_write  out  NSLAVE             one-hot write strobe, subset of s_sel
//  s_rdata  in   NSLAVE*DATA_W      packed slave read data; sync slaves, valid 1 cycle after strobe
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE; m_ready, m_err, s_sel, s_write = 0;
//   m_rdata, s_addr, s_wdata, s_width = 0; wait counter = 0.
//  Reset mid-transaction: strobes drop with rst_n low. The transaction is abandoned with no m_ready.
//   The master must re-issue it.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE: on m_req=1 (cycle A), latch region, local address, wdata, width and write -> ISSUE.
//   m_req is sampled only in IDLE.
//  ISSUE (A+1), mapped region: s_sel[r]=1, and s_write[r]=m_write, for exactly 1 cycle.
//   Load cnt=LAT_VEC[4r+:4].
//   Next state: WAIT if cnt!=0, else DONE.
//  ISSUE, unmapped region: no strobe -> DONE with error flag set.
//  WAIT: cnt decrements by 1 each cycle; leaves for DONE on the cycle cnt==1. No strobe is asserted.
//  DONE: registers m_rdata <= s_rdata[r] (read) and asserts m_ready=1 for 1 cycle -> IDLE.
//   Read latency: m_ready at cycle A+2+LAT[r] (LAT=0 -> A+2).
//   Writes: m_rdata holds its previous value.
//   Error: m_err=1 and m_rdata=0.
//  Back-to-back: a request held high is re-accepted in the cycle after m_ready.
//   Max throughput is 1 per 3+LAT cycles.
//  s_addr = latched m_addr[ADDR_W-SEL_W-1:0], constant from ISSUE until next accept.
//   s_wdata and s_width follow the same rule.
//  m_err=0 whenever m_ready=0. s_write is never set without the matching s_sel bit.
//  The m_width value is passed through unchanged; no alignment check in this block.
// TESTING
//  1. Reset: rst_n low mid-WAIT -> s_sel=0, m_ready=0 asynchronously; IDLE after release, no stray pulse.
//  2. Read r=1 (LAT=0), s_rdata[1]=32'hDEADBEEF, accept at cycle A:
//     s_sel=4'b0010 at A+1 only; m_ready and m_rdata=32'hDEADBEEF at A+2.
//  3. Write r=2, LAT=3, m_addr=11'h404, m_wdata=32'h000000A5, m_width=4'b0001:
//     s_write=4'b0100 for 1 cycle; s_addr=9'h004; m_ready at A+5; m_rdata unchanged.
//  4. Read to unmapped region (MAP_MASK=4'b0111, m_addr=11'h600):
//     no s_sel ever; m_ready and m_err at A+2; m_rdata=0.
//  5. m_req held high for 3 reads to r=0 (LAT=0): accepts at A, A+3, A+6; exactly 3 m_ready pulses.
//  6. m_addr/m_wdata changed during WAIT: s_addr/s_wdata stay at the latched values;
//     the response belongs to the original request.

Source files
------------

// File: rtl/dbus_region_decoder_if.sv
// CPU data-port bus between the master and the region decoder.
// Handshake: the master raises m_req with stable m_addr/m_wdata/m_width/m_write and holds it until
// m_ready; m_ready is a one-cycle completion pulse, with m_err and m_rdata valid in that same cycle.
interface dbus_region_decoder_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              m_req;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [3:0]        m_width;
   logic              m_write;
   logic              m_ready;
   logic              m_err;
   logic [DATA_W-1:0] m_rdata;

   modport master (
      output m_req, m_addr, m_wdata, m_width, m_write,
      input  m_ready, m_err, m_rdata
   );

   modport slave (
      input  m_req, m_addr, m_wdata, m_width, m_write,
      output m_ready, m_err, m_rdata
   );
endinterface

// File: rtl/dbus_region_decoder.sv
// N-way region decoder between the CPU data port and memory-mapped slaves, with per-region
// wait states, a registered read-data return and an error response for unmapped regions.
module dbus_region_decoder #(
   parameter int                  ADDR_W   = 11,
   parameter int                  DATA_W   = 32,
   parameter int                  NSLAVE   = 4,
   parameter int                  SEL_W    = 2,
   parameter logic [4*NSLAVE-1:0] LAT_VEC  = '0,
   parameter logic [NSLAVE-1:0]   MAP_MASK = '1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   dbus_region_decoder_if.slave       bus,
   output logic [NSLAVE-1:0]          s_sel,
   output logic [ADDR_W-SEL_W-1:0]    s_addr,
   output logic [DATA_W-1:0]          s_wdata,
   output logic [3:0]                 s_width,
   output logic [NSLAVE-1:0]          s_write,
   input  logic [NSLAVE*DATA_W-1:0]   s_rdata,
   output logic [1:0]                 dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                accept;
   logic                enter_done;

   logic [SEL_W-1:0]    region_q;
   logic                write_q;
   logic [3:0]          cnt_q;
   logic                ready_q;
   logic                err_q;
   logic [DATA_W-1:0]   rdata_q;

   logic [SEL_W-1:0]    req_region;
   logic [NSLAVE-1:0]   req_onehot;
   logic                req_mapped;
   logic                region_mapped;
   logic [3:0]          lat_sel;
   logic [DATA_W-1:0]   region_rdata;

   // Decode of the incoming request, used only on the accept cycle
   assign req_region = bus.m_addr[ADDR_W-1 -: SEL_W];
   assign req_onehot = {{(NSLAVE-1){1'b0}}, 1'b1} << req_region;
   assign req_mapped = MAP_MASK[req_region];

   // Decode of the latched region, valid from ISSUE until the next accept
   assign region_mapped = MAP_MASK[region_q];
   assign lat_sel       = LAT_VEC[{region_q, 2'b00} +: 4];
   assign region_rdata  = s_rdata[int'(region_q)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      enter_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.m_req) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!region_mapped || (lat_sel == 4'd0)) begin
               enter_done = 1'b1;
               state_d    = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) begin
               enter_done = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture: everything the slave sees stays frozen until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_q <= '0;
         write_q  <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_width  <= '0;
      end else if (accept) begin
         region_q <= req_region;
         write_q  <= bus.m_write;
         s_addr   <= bus.m_addr[ADDR_W-SEL_W-1:0];
         s_wdata  <= bus.m_wdata;
         s_width  <= bus.m_width;
      end
   end

   // Strobes are registered off the accept so they are high exactly during ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_sel   <= '0;
         s_write <= '0;
      end else if (accept && req_mapped) begin
         s_sel   <= req_onehot;
         s_write <= bus.m_write ? req_onehot : '0;
      end else begin
         s_sel   <= '0;
         s_write <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (state_q == ISSUE) begin
         cnt_q <= lat_sel;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Response registers are loaded on the edge entering DONE, so they are valid during DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= enter_done;
         err_q   <= enter_done && !region_mapped;
         if (enter_done) begin
            if (!region_mapped) begin
               rdata_q <= '0;
            end else if (!write_q) begin
               rdata_q <= region_rdata;
            end
         end
      end
   end

   assign bus.m_ready = ready_q;
   assign bus.m_err   = err_q;
   assign bus.m_rdata = rdata_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_dbus_region_decoder.sv
// Directed bench for dbus_region_decoder: a transaction-level model checked every cycle,
// plus literal expectations on selected transactions.
module tb_dbus_region_decoder;

  localparam logic [15:0] LAT_VEC  = 16'h0300;
  localparam logic [3:0]  MAP_MASK = 4'b0111;

  logic         clk;
  logic         rst_n;
  logic [3:0]   s_sel;
  logic [8:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_width;
  logic [3:0]   s_write;
  logic [127:0] s_rdata;
  logic [1:0]   dbg_state;
  logic [31:0]  srd [4];

  dbus_region_decoder_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  dbus_region_decoder #(
    .ADDR_W(11), .DATA_W(32), .NSLAVE(4), .SEL_W(2),
    .LAT_VEC(LAT_VEC), .MAP_MASK(MAP_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
    .s_write(s_write), .s_rdata(s_rdata), .dbg_state(dbg_state)
  );

  assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Region r decodes from addr[10:9]; mapped regions strobe in the cycle after accept and
  // respond 2+lat cycles after accept; unmapped ones respond after 2 cycles with an error.
  int          lat_tab [4] = '{0, 0, 3, 0};
  bit          map_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int          edge_n      = 0;
  int          strobe_edge = -100;
  int          done_edge   = -10;
  logic [1:0]  mdl_region  = 2'd0;
  logic        mdl_write   = 1'b0;
  logic [8:0]  exp_saddr   = '0;
  logic [31:0] exp_wdata   = '0;
  logic [3:0]  exp_width   = '0;
  logic [31:0] exp_rdata   = '0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst_n) begin
      done_edge   = edge_n - 1;
      strobe_edge = -100;
      exp_rdata   = '0;
      exp_saddr   = '0;
      exp_wdata   = '0;
      exp_width   = '0;
    end else begin
      if (edge_n == done_edge) begin
        if (!map_tab[mdl_region]) exp_rdata = '0;
        else if (!mdl_write)      exp_rdata = srd[mdl_region];
      end
      if (edge_n > done_edge + 1 && bus.m_req) begin
        mdl_region  = bus.m_addr[10:9];
        mdl_write   = bus.m_write;
        exp_saddr   = bus.m_addr[8:0];
        exp_wdata   = bus.m_wdata;
        exp_width   = bus.m_width;
        strobe_edge = edge_n;
        done_edge   = edge_n + 1 + (map_tab[mdl_region] ? lat_tab[mdl_region] : 0);
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    logic [3:0] exp_sel;
    logic       exp_ready;
    if (!rst_n) begin
      check("rst_s_sel", s_sel, 4'b0);
      check("rst_s_write", s_write, 4'b0);
      check("rst_m_ready", bus.m_ready, 1'b0);
      check("rst_m_err", bus.m_err, 1'b0);
      check("rst_m_rdata", bus.m_rdata, 32'h0);
      check("rst_s_addr", s_addr, 9'h0);
    end else begin
      exp_sel   = (edge_n == strobe_edge && map_tab[mdl_region]) ? (4'b0001 << mdl_region) : 4'b0000;
      exp_ready = (edge_n == done_edge);
      check("s_sel", s_sel, exp_sel);
      check("s_write", s_write, mdl_write ? exp_sel : 4'b0000);
      check("m_ready", bus.m_ready, exp_ready);
      check("m_err", bus.m_err, exp_ready && !map_tab[mdl_region]);
      check("m_rdata", bus.m_rdata, exp_rdata);
      check("s_addr", s_addr, exp_saddr);
      check("s_wdata", s_wdata, exp_wdata);
      check("s_width", s_width, exp_width);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(
    input  logic [10:0] addr, input logic [31:0] wdata, input logic [3:0] width, input logic wr,
    input  int chg_k, input logic [10:0] chg_addr, input logic [31:0] chg_wdata,
    output int k_rdy, output logic [3:0] sel_or, output int sel_cnt, output int sel_k,
    output logic [3:0] wr_or, output logic err, output logic [31:0] rdata, output logic [8:0] saddr
  );
    @(negedge clk);
    #1;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_width = width;
    bus.m_write = wr;
    bus.m_req   = 1'b1;
    k_rdy = -1; sel_or = '0; sel_cnt = 0; sel_k = -1; wr_or = '0; err = 1'b0; rdata = '0; saddr = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_sel != 4'b0) begin
        sel_or  = sel_or | s_sel;
        sel_cnt = sel_cnt + 1;
        sel_k   = k;
      end
      wr_or = wr_or | s_write;
      if (bus.m_ready) begin
        k_rdy = k;
        err   = bus.m_err;
        rdata = bus.m_rdata;
        saddr = s_addr;
        break;
      end
      if (k == chg_k) begin
        #1;
        bus.m_addr  = chg_addr;
        bus.m_wdata = chg_wdata;
      end
    end
    #1 bus.m_req = 1'b0;
    check("txn_completed", k_rdy > 0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int          k_rdy, sel_cnt, sel_k, n_rdy;
  int          rk [3];
  logic [3:0]  sel_or, wr_or;
  logic        err;
  logic [31:0] rdata;
  logic [8:0]  saddr;

  initial begin
    srd[0] = 32'h11110000;
    srd[1] = 32'hDEADBEEF;
    srd[2] = 32'hCAFE0002;
    srd[3] = 32'h33333333;
    bus.m_req = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_width = '0; bus.m_write = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_m_ready", bus.m_ready, 1'b0);
    check("post_rst_m_rdata", bus.m_rdata, 32'h0);
    check("post_rst_s_sel", s_sel, 4'b0);

    // Read region 1, no wait states
    do_txn(11'h20C, 32'h0, 4'hF, 1'b0, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("rd1_latency", k_rdy, 2);
    check("rd1_sel", sel_or, 4'b0010);
    check("rd1_sel_cycle", sel_k, 1);
    check("rd1_sel_count", sel_cnt, 1);
    check("rd1_rdata", rdata, 32'hDEADBEEF);
    check("rd1_err", err, 1'b0);

    // Write region 2, three wait states; read data must hold
    do_txn(11'h404, 32'h000000A5, 4'b0001, 1'b1, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("wr2_latency", k_rdy, 5);
    check("wr2_write", wr_or, 4'b0100);
    check("wr2_sel_count", sel_cnt, 1);
    check("wr2_s_addr", saddr, 9'h004);
    check("wr2_rdata_hold", rdata, 32'hDEADBEEF);
    check("wr2_s_wdata", s_wdata, 32'h000000A5);
    check("wr2_s_width", s_width, 4'b0001);

    // Read to unmapped region 3
    do_txn(11'h600, 32'h0, 4'hF, 1'b0, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("unm_latency", k_rdy, 2);
    check("unm_no_sel", sel_cnt, 0);
    check("unm_err", err, 1'b1);
    check("unm_rdata", rdata, 32'h0);

    // Write to unmapped region 3
    do_txn(11'h7FC, 32'hFFFF0000, 4'b1100, 1'b1, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("unm_wr_no_write", wr_or, 4'b0000);
    check("unm_wr_err", err, 1'b1);

    // Write region 0, no wait states
    do_txn(11'h01C, 32'h87654321, 4'b1100, 1'b1, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("wr0_latency", k_rdy, 2);
    check("wr0_write", wr_or, 4'b0001);
    check("wr0_s_width", s_width, 4'b1100);

    // Request held high for three reads of region 0
    @(negedge clk);
    #1;
    bus.m_addr = 11'h010; bus.m_write = 1'b0; bus.m_width = 4'hF; bus.m_req = 1'b1;
    n_rdy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.m_ready) begin
        if (n_rdy < 3) rk[n_rdy] = k;
        n_rdy = n_rdy + 1;
        if (n_rdy == 3) #1 bus.m_req = 1'b0;
      end
    end
    bus.m_req = 1'b0;
    check("b2b_count", n_rdy, 3);
    check("b2b_first", rk[0], 2);
    check("b2b_second", rk[1], 5);
    check("b2b_third", rk[2], 8);
    check("b2b_rdata", bus.m_rdata, 32'h11110000);

    // Address/data changed while waiting must not affect the request in flight
    do_txn(11'h410, 32'h00000055, 4'hF, 1'b0, 2, 11'h0A8, 32'h12345678,
           k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("chg_latency", k_rdy, 5);
    check("chg_rdata", rdata, 32'hCAFE0002);
    check("chg_s_addr", saddr, 9'h010);
    check("chg_s_wdata", s_wdata, 32'h00000055);
    check("chg_sel", sel_or, 4'b0100);

    // Reset during WAIT abandons the write
    @(negedge clk);
    #1;
    bus.m_addr = 11'h404; bus.m_wdata = 32'h000000A5; bus.m_width = 4'b0001; bus.m_write = 1'b1;
    bus.m_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_s_sel", s_sel, 4'b0);
    check("async_rst_m_ready", bus.m_ready, 1'b0);
    check("async_rst_s_addr", s_addr, 9'h0);
    bus.m_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    n_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.m_ready) n_rdy = n_rdy + 1;
    end
    check("rst_no_stray_ready", n_rdy, 0);

    // Recovery after reset
    do_txn(11'h200, 32'h0, 4'hF, 1'b0, 0, '0, '0, k_rdy, sel_or, sel_cnt, sel_k, wr_or, err, rdata, saddr);
    check("rec_latency", k_rdy, 2);
    check("rec_rdata", rdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
